delay_line_ram: RTL and testbench

- Parametrised circular-buffer RAM that delays a sample stream by a runtime-selectable number of samples.
- Successor to the plain dual-port 512x8 RAM. Write and read addressing are generated internally from a free-running write pointer, so the caller supplies only a delay offset.
- Adds warm-up tracking, a zero-delay bypass and synchronous reset of pointer state.
- Sits between the waveform generator (sample source) and the output stage in the signal-generator datapath.

---
 rtl/delay_line_ram.sv | 84 ++++++++
 tb/tb_delay_line_ram.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/delay_line_ram.sv
// Circular-buffer delay line: delays a sample stream by a runtime offset.
// Write/read addressing comes from an internal free-running write pointer.
module delay_line_ram #(
    parameter int ADDRESS_WIDTH = 9,
    parameter int DATA_WIDTH    = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     sample_en,
    input  logic [DATA_WIDTH-1:0]    din,
    input  logic [ADDRESS_WIDTH-1:0] offset,
    output logic [DATA_WIDTH-1:0]    dout,
    output logic                     dout_valid,
    output logic                     dout_primed,
    output logic [ADDRESS_WIDTH:0]   fill_count
);

    localparam int DEPTH = 2 ** ADDRESS_WIDTH;
    localparam logic [ADDRESS_WIDTH:0] FULL = (ADDRESS_WIDTH+1)'(DEPTH);

    logic [DATA_WIDTH-1:0]    r_mem [DEPTH];
    logic [ADDRESS_WIDTH-1:0] r_wr_ptr;
    logic [ADDRESS_WIDTH:0]   r_fill;
    logic [DATA_WIDTH-1:0]    r_dout;
    logic                     r_valid;
    logic                     r_primed;

    logic                     w_accept;
    logic                     w_bypass;
    logic                     w_primed;
    logic [ADDRESS_WIDTH-1:0] w_rd_addr;

    assign w_accept  = sample_en && !rst;
    assign w_bypass  = (offset == '0);
    assign w_rd_addr = r_wr_ptr - offset;
    assign w_primed  = w_bypass || (r_fill >= {1'b0, offset});

    // Sample storage; deliberately not cleared by reset.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Write pointer and saturating fill counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_fill   <= '0;
        end else if (sample_en) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
            if (r_fill != FULL) begin
                r_fill <= r_fill + 1'b1;
            end
        end
    end

    // Output register: bypass, history read, or zero during warm-up.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dout   <= '0;
            r_valid  <= 1'b0;
            r_primed <= 1'b0;
        end else if (sample_en) begin
            r_valid  <= 1'b1;
            r_primed <= w_primed;
            if (w_bypass) begin
                r_dout <= din;
            end else if (w_primed) begin
                r_dout <= r_mem[w_rd_addr];
            end else begin
                r_dout <= '0;
            end
        end else begin
            r_valid <= 1'b0;
        end
    end

    assign dout        = r_dout;
    assign dout_valid  = r_valid;
    assign dout_primed = r_primed;
    assign fill_count  = r_fill;

endmodule

// File: tb/tb_delay_line_ram.sv
// Directed bench for delay_line_ram with a 16-deep buffer.
// Each step drives one cycle and checks outputs #1 after the edge.
module tb_delay_line_ram;

    localparam int AW = 4;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          sample_en;
    logic [DW-1:0] din;
    logic [AW-1:0] offset;
    logic [DW-1:0] dout;
    logic          dout_valid;
    logic          dout_primed;
    logic [AW:0]   fill_count;

    int checks   = 0;
    int failures = 0;

    delay_line_ram #(
        .ADDRESS_WIDTH(AW),
        .DATA_WIDTH(DW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .sample_en(sample_en),
        .din(din),
        .offset(offset),
        .dout(dout),
        .dout_valid(dout_valid),
        .dout_primed(dout_primed),
        .fill_count(fill_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset(input logic en);
        rst       = 1'b1;
        sample_en = en;
        din       = 8'd99;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        sample_en = 1'b0;
    endtask

    task automatic idle();
        sample_en = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic smp(input string tag, input logic [DW-1:0] d,
                       input logic [AW-1:0] off,
                       input logic [DW-1:0] exp_d,
                       input logic exp_p);
        sample_en = 1'b1;
        din       = d;
        offset    = off;
        @(posedge clk);
        #1;
        sample_en = 1'b0;
        chk({tag, ".dout"}, 32'(dout), 32'(exp_d));
        chk({tag, ".primed"}, 32'(dout_primed), 32'(exp_p));
        chk({tag, ".valid"}, 32'(dout_valid), 32'd1);
    endtask

    task automatic chk_quiet(input string tag, input logic [DW-1:0] exp_d,
                             input logic exp_p, input int exp_f);
        chk({tag, ".dout"}, 32'(dout), 32'(exp_d));
        chk({tag, ".valid"}, 32'(dout_valid), 32'd0);
        chk({tag, ".primed"}, 32'(dout_primed), 32'(exp_p));
        chk({tag, ".fill"}, 32'(fill_count), 32'(exp_f));
    endtask

    initial begin
        rst       = 1'b1;
        sample_en = 1'b0;
        din       = '0;
        offset    = '0;
        @(posedge clk);
        do_reset(1'b0);
        chk_quiet("rst", 8'd0, 1'b0, 0);
        idle();
        idle();
        chk_quiet("idle2", 8'd0, 1'b0, 0);

        // Zero-delay bypass.
        smp("byp0", 8'd5, 4'd0, 8'd5, 1'b1);
        smp("byp1", 8'd6, 4'd0, 8'd6, 1'b1);
        smp("byp2", 8'd7, 4'd0, 8'd7, 1'b1);
        chk("byp.fill", 32'(fill_count), 32'd3);
        idle();
        chk_quiet("byp.hold", 8'd7, 1'b1, 3);

        // Offset 3 warm-up then history.
        do_reset(1'b0);
        for (int k = 1; k <= 8; k++) begin
            smp($sformatf("off3_%0d", k), 8'(k), 4'd3,
                (k > 3) ? 8'(k - 3) : 8'd0, k > 3);
        end

        // Maximum offset with wrap-around.
        do_reset(1'b0);
        for (int k = 0; k < 40; k++) begin
            smp($sformatf("max_%0d", k), 8'(k), 4'd15,
                (k >= 15) ? 8'(k - 15) : 8'd0, k >= 15);
        end
        chk("max.fill", 32'(fill_count), 32'd16);

        // Offset change mid-stream.
        do_reset(1'b0);
        smp("chg0", 8'd10, 4'd2, 8'd0, 1'b0);
        smp("chg1", 8'd11, 4'd2, 8'd0, 1'b0);
        smp("chg2", 8'd12, 4'd2, 8'd10, 1'b1);
        smp("chg3", 8'd13, 4'd2, 8'd11, 1'b1);
        smp("chg4", 8'd14, 4'd1, 8'd13, 1'b1);
        smp("chg5", 8'd15, 4'd1, 8'd14, 1'b1);

        // Reset mid-stream: stale contents must not surface.
        do_reset(1'b0);
        for (int k = 0; k < 10; k++) begin
            smp($sformatf("pre_%0d", k), 8'(100 + k), 4'd0,
                8'(100 + k), 1'b1);
        end
        do_reset(1'b0);
        chk_quiet("mid.rst", 8'd0, 1'b0, 0);
        for (int k = 0; k < 4; k++) begin
            smp($sformatf("warm_%0d", k), 8'(50 + k), 4'd4, 8'd0, 1'b0);
        end
        smp("warm_4", 8'd54, 4'd4, 8'd50, 1'b1);

        // Reset wins over a coincident sample strobe.
        smp("co0", 8'd1, 4'd0, 8'd1, 1'b1);
        do_reset(1'b1);
        chk_quiet("co.rst", 8'd0, 1'b0, 0);
        idle();
        chk_quiet("co.idle", 8'd0, 1'b0, 0);
        smp("co1", 8'd33, 4'd1, 8'd0, 1'b0);
        smp("co2", 8'd34, 4'd1, 8'd33, 1'b1);
        chk("co.fill", 32'(fill_count), 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
